inv_round_core: RTL and testbench

INV_ROUND_CORE -- requirements
Module: inv_round_core

---
 rtl/inv_round_core.sv | 132 +++++++++++++
 tb/tb_inv_round_core.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/inv_round_core.sv
// inv_round_core: one AES decryption round stage after InvSubBytes.
// Accepts a 128-bit state, applies InvShiftRows and AddRoundKey in the
// accept cycle, then optionally runs InvMixColumns one column per cycle
// before presenting the result under a valid/ready handshake.
module inv_round_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    input  logic         in_mix_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [127:0] work;
    logic [1:0]   cnt;
    logic         mix_flag;

    logic [127:0] shifted;
    logic [127:0] work_mixed;
    logic [6:0]   base;
    logic [31:0]  col_out;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One InvMixColumns column; products 9, b, d, e are built from the
    // x, x^2 and x^3 multiples of each input byte.
    function automatic logic [31:0] inv_mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                                input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        a[0] = a0;
        a[1] = a1;
        a[2] = a2;
        a[3] = a3;
        for (int i = 0; i < 4; i++) begin
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        inv_mix_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                       m9[0] ^ me[1] ^ mb[2] ^ md[3],
                       md[0] ^ m9[1] ^ me[2] ^ mb[3],
                       mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // InvShiftRows: row r rotates right by r byte positions.
    always_comb begin
        shifted = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                shifted[127 - 32*r - 8*c -: 8] = in_data[127 - 32*r - 8*((c - r + 4) % 4) -: 8];
            end
        end
    end

    // Working register with column cnt replaced by its InvMixColumns result.
    always_comb begin
        base       = 7'd127 - {2'b00, cnt, 3'b000};
        col_out    = inv_mix_col(work[base -: 8], work[base - 7'd32 -: 8],
                                 work[base - 7'd64 -: 8], work[base - 7'd96 -: 8]);
        work_mixed = work;
        work_mixed[base -: 8]          = col_out[31:24];
        work_mixed[base - 7'd32 -: 8]  = col_out[23:16];
        work_mixed[base - 7'd64 -: 8]  = col_out[15:8];
        work_mixed[base - 7'd96 -: 8]  = col_out[7:0];
    end

    // Control FSM and datapath: load on accept, mix column by column, hold until drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            work     <= '0;
            cnt      <= 2'd0;
            mix_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= shifted ^ in_key;
                        mix_flag <= in_mix_en;
                        cnt      <= 2'd0;
                        state    <= in_mix_en ? COL : DONE;
                    end
                end
                COL: begin
                    if (mix_flag) begin
                        work <= work_mixed;
                    end
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = work;

endmodule

// File: tb/tb_inv_round_core.sv
// tb_inv_round_core: directed vector table plus hand-written handshake,
// backpressure and reset corner cases for inv_round_core.
module tb_inv_round_core;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         in_mix_en;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int errors;
    int checks;

    typedef struct {
        logic [127:0] data;
        logic [127:0] key;
        logic         mix;
        logic [127:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    inv_round_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_mix_en (in_mix_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    // Present one state, measure the cycles after the accept edge until
    // out_valid, check the result, then drain it.
    task automatic applyStimulus(input string name, input logic [127:0] data, input logic [127:0] key,
                                 input logic mix, input logic [127:0] exp_data, input logic ready_early);
        int extra;
        checkOutput({name, " in_ready"}, {127'd0, in_ready}, 128'd1);
        in_data   = data;
        in_key    = key;
        in_mix_en = mix;
        in_valid  = 1'b1;
        out_ready = ready_early;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        in_key   = '0;
        extra    = 0;
        while (!out_valid && extra < 12) begin
            checkOutput({name, " busy in_ready"}, {127'd0, in_ready}, 128'd0);
            tick();
            extra++;
        end
        checkOutput({name, " latency"}, 128'(extra), mix ? 128'd4 : 128'd0);
        checkOutput({name, " data"}, out_data, exp_data);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({name, " drained out_valid"}, {127'd0, out_valid}, 128'd0);
        checkOutput({name, " drained in_ready"}, {127'd0, in_ready}, 128'd1);
    endtask

    initial begin
        logic [127:0] held;
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        in_mix_en = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0, 1'b0,
                    128'h00010203070405060a0b08090d0e0f0c};
        vecs[1] = '{128'h8e8e8e8e4d4d4d4da1a1a1a1bcbcbcbc, 128'h0, 1'b1,
                    128'hdbdbdbdb131313135353535345454545};
        vecs[2] = '{128'h0, 128'h8e8e8e8e4d4d4d4da1a1a1a1bcbcbcbc, 1'b1,
                    128'hdbdbdbdb131313135353535345454545};
        vecs[3] = '{128'h0, 128'h0, 1'b1, 128'h0};
        vecs[4] = '{128'h0, 128'h00112233445566778899aabbccddeeff, 1'b0,
                    128'h00112233445566778899aabbccddeeff};
        vecs[5] = '{128'h01010101010101010101010101010101, 128'h0, 1'b1,
                    128'h01010101010101010101010101010101};
        vecs[6] = '{128'h0, 128'h9fc6d54ddcc6d57e58c6d7bd9dc6d6f8, 1'b1,
                    128'hf2c6d42d0ac6d42622c6d4315cc6d54c};
        vecs[7] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hffffffffffffffffffffffffffffffff, 1'b0,
                    128'hfffefdfcf8fbfaf9f5f4f7f6f2f1f0f3};
        vecs[8] = '{128'h9fc6d54dc6d57edcd7bd58c6f89dc6d6, 128'h0, 1'b1,
                    128'hf2c6d42d0ac6d42622c6d4315cc6d54c};

        // Reset held for two cycles.
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("reset in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("reset out_data", out_data, 128'd0);

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].data, vecs[i].key,
                          vecs[i].mix, vecs[i].exp_data, 1'b0);
        end

        // out_ready held high throughout a mix transfer must not shorten COL.
        applyStimulus("early ready", vecs[6].data, vecs[6].key, 1'b1, vecs[6].exp_data, 1'b1);

        // Backpressure: hold DONE with a competing in_valid.
        in_data   = vecs[0].data;
        in_key    = '0;
        in_mix_en = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_data  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        in_key   = 128'h1234;
        held     = vecs[0].exp_data;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bp out_valid %0d", i), {127'd0, out_valid}, 128'd1);
            checkOutput($sformatf("bp out_data %0d", i), out_data, held);
            checkOutput($sformatf("bp in_ready %0d", i), {127'd0, in_ready}, 128'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp release in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("bp release out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("bp no capture", out_data, held);

        // Reset mid-COL at cnt=2 discards the partial result.
        in_data   = vecs[1].data;
        in_key    = '0;
        in_mix_en = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("midcol busy", {127'd0, in_ready}, 128'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midcol rst in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("midcol rst out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("midcol rst out_data", out_data, 128'd0);
        applyStimulus("after rst", vecs[0].data, vecs[0].key, vecs[0].mix, vecs[0].exp_data, 1'b0);

        // Reset wins over out_ready in DONE.
        in_data   = vecs[7].data;
        in_key    = vecs[7].key;
        in_mix_en = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("done pre-rst out_valid", {127'd0, out_valid}, 128'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        checkOutput("done rst out_data", out_data, 128'd0);
        checkOutput("done rst in_ready", {127'd0, in_ready}, 128'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
